// File: rtl/me_ref_row_feeder_if.sv
// Reference-row feeder bus: job control, reference memory port and packed row output.
`timescale 1ns/1ps
interface me_ref_row_feeder_if #(
    parameter int ADDR_W = 16
);
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              busy_o;
    logic              done_o;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [63:0]       mem_rdata_i;
    logic [183:0]      data_out;
    logic              data_valid_o;

    modport master (
        output start_i, base_addr_i, mem_rdata_i,
        input  busy_o, done_o, mem_rd_en_o, mem_addr_o,
        input  data_out, data_valid_o
    );

    modport slave (
        input  start_i, base_addr_i, mem_rdata_i,
        output busy_o, done_o, mem_rd_en_o, mem_addr_o,
        output data_out, data_valid_o
    );
endinterface

// File: rtl/me_ref_row_feeder.sv
// Fetches search-area rows as three 64-bit words and packs them into 184-bit rows.
`timescale 1ns/1ps
module me_ref_row_feeder #(
    parameter int ADDR_W      = 16,
    parameter int NUM_ROWS    = 23,
    parameter int LINE_STRIDE = 8
) (
    input logic clk_i,
    input logic rst_n_i,
    me_ref_row_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [7:0]        LAST_ROW = 8'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(LINE_STRIDE);

    state_t            state;
    logic [7:0]        row;
    logic [1:0]        word;
    logic [ADDR_W-1:0] row_addr;
    logic              rd_q;
    logic [1:0]        wsel_q;
    logic [63:0]       stage0;
    logic [63:0]       stage1;
    logic              last_rd;
    logic [1:0]        word_nxt;

    assign last_rd  = (row == LAST_ROW) && (word == 2'd2);
    assign word_nxt = word + 2'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            row              <= '0;
            word             <= '0;
            row_addr         <= '0;
            rd_q             <= 1'b0;
            wsel_q           <= '0;
            stage0           <= '0;
            stage1           <= '0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.mem_rd_en_o  <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.data_out     <= '0;
            bus.data_valid_o <= 1'b0;
        end else begin
            bus.done_o       <= 1'b0;
            bus.data_valid_o <= 1'b0;
            // rd_q/wsel_q tag the read data that arrives in the following cycle
            rd_q             <= bus.mem_rd_en_o;
            wsel_q           <= word;

            if (rd_q) begin
                unique case (wsel_q)
                    2'd0: stage0 <= bus.mem_rdata_i;
                    2'd1: stage1 <= bus.mem_rdata_i;
                    default: begin
                        bus.data_out     <= {bus.mem_rdata_i[55:0], stage1, stage0};
                        bus.data_valid_o <= 1'b1;
                    end
                endcase
            end

            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state           <= FETCH;
                        bus.busy_o      <= 1'b1;
                        bus.mem_rd_en_o <= 1'b1;
                        bus.mem_addr_o  <= bus.base_addr_i;
                        row_addr        <= bus.base_addr_i;
                        row             <= '0;
                        word            <= '0;
                    end
                end
                FETCH: begin
                    if (last_rd) begin
                        bus.mem_rd_en_o <= 1'b0;
                        state           <= DRAIN;
                    end else if (word == 2'd2) begin
                        word           <= '0;
                        row            <= row + 8'd1;
                        row_addr       <= row_addr + STRIDE;
                        bus.mem_addr_o <= row_addr + STRIDE;
                    end else begin
                        word           <= word_nxt;
                        bus.mem_addr_o <= row_addr + ADDR_W'(word_nxt);
                    end
                end
                DRAIN: begin
                    // Only the final row can be emitted while draining
                    if (bus.data_valid_o) begin
                        state      <= IDLE;
                        bus.busy_o <= 1'b0;
                        bus.done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_ref_row_feeder.sv
// Directed bench for me_ref_row_feeder: 23-row jobs, restarts, reset abort, wrap.
`timescale 1ns/1ps
module tb_me_ref_row_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    me_ref_row_feeder_if #(.ADDR_W(16)) bus_a ();
    me_ref_row_feeder_if #(.ADDR_W(16)) bus_b ();

    me_ref_row_feeder #(.ADDR_W(16), .NUM_ROWS(23), .LINE_STRIDE(8)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_a)
    );

    me_ref_row_feeder #(.ADDR_W(16), .NUM_ROWS(1), .LINE_STRIDE(8)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_b)
    );

    int vec  = 0;
    int miss = 0;
    logic [183:0] first_row;

    function automatic logic [63:0] memf(input logic [15:0] a);
        if (a == 16'h0000) return 64'hAA11223344556677;
        return {8{a[7:0]}};
    endfunction

    function automatic logic [183:0] rowf(input logic [15:0] base, input int r);
        logic [15:0] a;
        logic [63:0] w0, w1, w2;
        a  = base + 16'(r * 8);
        w0 = memf(a);
        w1 = memf(a + 16'd1);
        w2 = memf(a + 16'd2);
        return {w2[55:0], w1, w0};
    endfunction

    always @(posedge clk) begin
        bus_a.mem_rdata_i <= memf(bus_a.mem_addr_o);
        bus_b.mem_rdata_i <= memf(bus_b.mem_addr_o);
    end

    task automatic chk(input string tag, input logic [183:0] got, input logic [183:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 of a 23-row job on dut_a; returns in its done cycle
    task automatic watch_job(input logic [15:0] base, input int stray, output int nvalid);
        int n;
        int last;
        logic exp_rd, exp_v;
        n = 23;
        last = 3 * n + 3;
        nvalid = 0;
        for (int c = 1; c <= last; c++) begin
            exp_rd = (c <= 3 * n);
            exp_v  = (c >= 5) && (c <= 3 * n + 2) && ((c - 5) % 3 == 0);
            chk("rd_en", bus_a.mem_rd_en_o, exp_rd);
            if (exp_rd)
                chk("addr", bus_a.mem_addr_o, base + 16'(((c - 1) / 3) * 8 + (c - 1) % 3));
            chk("valid", bus_a.data_valid_o, exp_v);
            if (bus_a.data_valid_o) nvalid++;
            if (exp_v) chk("row", bus_a.data_out, rowf(base, (c - 5) / 3));
            if (c == 5) first_row = bus_a.data_out;
            chk("busy", bus_a.busy_o, c <= 3 * n + 2);
            chk("done", bus_a.done_o, c == last);
            if (c == last) chk("hold", bus_a.data_out, rowf(base, n - 1));
            if (stray > 0 && c == stray) bus_a.start_i = 1'b1;
            if (stray > 0 && c == stray + 1) bus_a.start_i = 1'b0;
            if (c < last) tick();
        end
    endtask

    initial begin
        int nv, nv2, cnt_v, cnt_d, cnt_r, cnt_b;
        bus_a.start_i = 1'b0;
        bus_a.base_addr_i = '0;
        bus_b.start_i = 1'b0;
        bus_b.base_addr_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus_a.busy_o, 1'b0);
        chk("rst_done", bus_a.done_o, 1'b0);
        chk("rst_rd", bus_a.mem_rd_en_o, 1'b0);
        chk("rst_addr", bus_a.mem_addr_o, 16'h0);
        chk("rst_data", bus_a.data_out, 184'h0);
        chk("rst_valid", bus_a.data_valid_o, 1'b0);
        chk("rst_rd_b", bus_b.mem_rd_en_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic job with a stray start at cycle 20
        bus_a.base_addr_i = 16'h0100;
        bus_a.start_i = 1'b1;
        tick();
        bus_a.start_i = 1'b0;
        watch_job(16'h0100, 20, nv);
        chk("rows_job1", nv, 23);
        chk("row0_lit", first_row,
            {56'h02020202020202, 64'h0101010101010101, 64'h0000000000000000});
        tick();

        // Back-to-back: start held through the done cycle
        bus_a.base_addr_i = 16'h0200;
        bus_a.start_i = 1'b1;
        tick();
        watch_job(16'h0200, 0, nv);
        tick();
        bus_a.start_i = 1'b0;
        watch_job(16'h0200, 0, nv2);
        chk("rows_b2b", nv + nv2, 46);
        tick();

        // Reset asserted during cycle 10 of a job
        bus_a.base_addr_i = 16'h0100;
        bus_a.start_i = 1'b1;
        tick();
        bus_a.start_i = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus_a.busy_o, 1'b0);
        chk("abort_done", bus_a.done_o, 1'b0);
        chk("abort_rd", bus_a.mem_rd_en_o, 1'b0);
        chk("abort_addr", bus_a.mem_addr_o, 16'h0);
        chk("abort_data", bus_a.data_out, 184'h0);
        chk("abort_valid", bus_a.data_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_v = 0; cnt_d = 0; cnt_r = 0; cnt_b = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus_a.data_valid_o) cnt_v++;
            if (bus_a.done_o) cnt_d++;
            if (bus_a.mem_rd_en_o) cnt_r++;
            if (bus_a.busy_o) cnt_b++;
        end
        chk("post_rst_valid", cnt_v, 0);
        chk("post_rst_done", cnt_d, 0);
        chk("post_rst_rd", cnt_r, 0);
        chk("post_rst_busy", cnt_b, 0);
        bus_a.base_addr_i = 16'h0300;
        bus_a.start_i = 1'b1;
        tick();
        bus_a.start_i = 1'b0;
        watch_job(16'h0300, 0, nv);
        chk("rows_clean", nv, 23);
        tick();

        // Single-row job wrapping past 0xFFFF
        bus_b.base_addr_i = 16'hFFFE;
        bus_b.start_i = 1'b1;
        tick();
        bus_b.start_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("w_rd", bus_b.mem_rd_en_o, c <= 3);
            if (c == 1) chk("w_addr0", bus_b.mem_addr_o, 16'hFFFE);
            if (c == 2) chk("w_addr1", bus_b.mem_addr_o, 16'hFFFF);
            if (c == 3) chk("w_addr2", bus_b.mem_addr_o, 16'h0000);
            chk("w_valid", bus_b.data_valid_o, c == 5);
            if (c == 5)
                chk("w_row", bus_b.data_out,
                    {56'h11223344556677, 64'hFFFFFFFFFFFFFFFF, 64'hFEFEFEFEFEFEFEFE});
            chk("w_busy", bus_b.busy_o, c <= 5);
            chk("w_done", bus_b.done_o, c == 6);
            if (c < 6) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
